// File: rtl/quad_pkg.sv
// Shared quadrature state encodings and the transition classifier used by the decoder.
package quad_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef struct packed {
    logic valid;
    logic illegal;
    logic up;
  } qd_dir_t;

  // Position of a phase state around the forward Gray cycle 00->01->11->10.
  function automatic logic [1:0] qs_idx(input logic [1:0] s);
    logic [1:0] idx;
    case (s)
      QS_00:   idx = 2'd0;
      QS_01:   idx = 2'd1;
      QS_11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic qd_dir_t qd_dir(input logic [1:0] prev, input logic [1:0] cur);
    qd_dir_t   r;
    logic [1:0] diff;
    diff = qs_idx(cur) - qs_idx(prev);
    r    = '0;
    case (diff)
      2'd1: begin r.valid = 1'b1; r.up = 1'b1; end
      2'd3: begin r.valid = 1'b1; r.up = 1'b0; end
      2'd2: r.illegal = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Multi-flop synchroniser for one asynchronous encoder phase.
module quad_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronises qa/qb, classifies each transition and
// maintains a wrapping up/down position counter with step, direction and error flags.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             up,
  output logic             step,
  output logic             err
);

  localparam int unsigned PRIME_EDGES = SYNC_STAGES + 1;
  localparam int unsigned PW          = $clog2(PRIME_EDGES + 1);

  logic             a_s, b_s;
  logic [1:0]       s;
  logic [1:0]       prev_q, prev_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             up_q, up_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             primed;
  qd_dir_t          dir;

  quad_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(qa), .q(a_s));
  quad_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(qb), .q(b_s));

  assign s      = {a_s, b_s};
  assign primed = (prime_q == PW'(PRIME_EDGES));

  // Until the synchroniser has flushed, prev only follows s so a static pin level is never counted.
  always_comb begin
    prime_d = prime_q;
    prev_d  = s;
    count_d = count_q;
    up_d    = up_q;
    step_d  = 1'b0;
    err_d   = err_q;
    dir     = qd_dir(prev_q, s);

    if (!primed) begin
      prime_d = prime_q + PW'(1);
    end else if (dir.valid) begin
      count_d = dir.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      up_d    = dir.up;
      step_d  = 1'b1;
    end else if (dir.illegal) begin
      err_d   = 1'b1;
    end

    // Clear discards a coincident step but lets direction and prev update.
    if (clear) begin
      count_d = '0;
      err_d   = 1'b0;
      step_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= '0;
      prev_q  <= QS_00;
      count_q <= '0;
      up_q    <= 1'b1;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prime_q <= prime_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      up_q    <= up_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign up    = up_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed, table-driven bench for quadrature_decoder with default parameters.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       reset, qa, qb, clear;
  logic [3:0] count;
  logic       up, step, err;

  int checks = 0;
  int errors = 0;

  quadrature_decoder dut (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .clear(clear),
    .count(count), .up(up), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pins;
    logic       exp_step;
    logic [3:0] exp_count;
    logic       exp_up;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] p, logic st, logic [3:0] c, logic u, logic e);
    vec_t v;
    v.pins = p; v.exp_step = st; v.exp_count = c; v.exp_up = u; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a pin state, then watch four edges: a legal step must pulse on exactly the third.
  task automatic apply(input vec_t v, input int idx);
    {qa, qb} = v.pins;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("step[v%0d,e%0d]", idx, i), 32'(step), (i == 2) ? 32'(v.exp_step) : 32'd0);
    end
    check($sformatf("count[v%0d]", idx), 32'(count), 32'(v.exp_count));
    check($sformatf("up[v%0d]", idx), 32'(up), 32'(v.exp_up));
    check($sformatf("err[v%0d]", idx), 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] fwd [7];
    int         step_seen;

    // Up 10 steps from 00
    vecs.push_back(mk(2'b01, 1, 4'd1, 1, 0));
    vecs.push_back(mk(2'b11, 1, 4'd2, 1, 0));
    vecs.push_back(mk(2'b10, 1, 4'd3, 1, 0));
    vecs.push_back(mk(2'b00, 1, 4'd4, 1, 0));
    vecs.push_back(mk(2'b01, 1, 4'd5, 1, 0));
    vecs.push_back(mk(2'b11, 1, 4'd6, 1, 0));
    vecs.push_back(mk(2'b10, 1, 4'd7, 1, 0));
    vecs.push_back(mk(2'b00, 1, 4'd8, 1, 0));
    vecs.push_back(mk(2'b01, 1, 4'd9, 1, 0));
    vecs.push_back(mk(2'b11, 1, 4'd10, 1, 0));
    // Down 12 steps, wrapping 0 -> 15
    vecs.push_back(mk(2'b01, 1, 4'd9, 0, 0));
    vecs.push_back(mk(2'b00, 1, 4'd8, 0, 0));
    vecs.push_back(mk(2'b10, 1, 4'd7, 0, 0));
    vecs.push_back(mk(2'b11, 1, 4'd6, 0, 0));
    vecs.push_back(mk(2'b01, 1, 4'd5, 0, 0));
    vecs.push_back(mk(2'b00, 1, 4'd4, 0, 0));
    vecs.push_back(mk(2'b10, 1, 4'd3, 0, 0));
    vecs.push_back(mk(2'b11, 1, 4'd2, 0, 0));
    vecs.push_back(mk(2'b01, 1, 4'd1, 0, 0));
    vecs.push_back(mk(2'b00, 1, 4'd0, 0, 0));
    vecs.push_back(mk(2'b10, 1, 4'd15, 0, 0));
    vecs.push_back(mk(2'b11, 1, 4'd14, 0, 0));
    // Up through 15 -> 0
    vecs.push_back(mk(2'b10, 1, 4'd15, 1, 0));
    vecs.push_back(mk(2'b00, 1, 4'd0, 1, 0));
    // Illegal 00 -> 11, then legal steps still count with err sticky
    vecs.push_back(mk(2'b11, 0, 4'd0, 1, 1));
    vecs.push_back(mk(2'b10, 1, 4'd1, 1, 1));
    vecs.push_back(mk(2'b11, 1, 4'd0, 0, 1));
    vecs.push_back(mk(2'b11, 0, 4'd0, 0, 1));

    reset = 1'b1; clear = 1'b0; qa = 1'b1; qb = 1'b1;
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_up", 32'(up), 32'd1);
    check("reset_step", 32'(step), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Priming: static 11 at release must never count
    reset = 1'b0;
    step_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step === 1'b1) step_seen++;
    end
    check("prime_steps", 32'(step_seen), 32'd0);
    check("prime_count", 32'(count), 32'd0);
    check("prime_err", 32'(err), 32'd0);

    reset = 1'b1; qa = 1'b0; qb = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    foreach (vecs[i]) apply(vecs[i], i);

    // Clear lands on the same edge the UP step 11->10 decodes
    {qa, qb} = 2'b10;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_step", 32'(step), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    check("clr_up", 32'(up), 32'd1);
    tick();
    check("clr_step_after", 32'(step), 32'd0);
    check("clr_count_after", 32'(count), 32'd0);

    // Seven forward steps to reach count 7 from state 10
    fwd[0] = 2'b00; fwd[1] = 2'b01; fwd[2] = 2'b11; fwd[3] = 2'b10;
    fwd[4] = 2'b00; fwd[5] = 2'b01; fwd[6] = 2'b11;
    for (int i = 0; i < 7; i++) begin
      {qa, qb} = fwd[i];
      for (int j = 0; j < 4; j++) tick();
    end
    check("pre_rst_count", 32'(count), 32'd7);
    check("pre_rst_up", 32'(up), 32'd1);

    // Reset while the 11->10 edge sits in the synchroniser
    {qa, qb} = 2'b10;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_up", 32'(up), 32'd1);
    check("mid_rst_step", 32'(step), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    step_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step === 1'b1) step_seen++;
    end
    check("mid_rst_steps", 32'(step_seen), 32'd0);
    check("mid_rst_count_hold", 32'(count), 32'd0);

    apply(mk(2'b00, 1, 4'd1, 1, 0), 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
